perf_cntr_bank: RTL and testbench



---
 rtl/perf_cntr_bank.sv | 183 ++++++++++++++++++
 tb/tb_perf_cntr_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_cntr_bank.sv
// Performance-counter bank: NUM_CNTRS event-selectable counters with preload,
// global enable/freeze, sticky overflow with interrupt and a shadowed 64-bit readout.
module perf_cntr_bank #(
    parameter int unsigned NUM_CNTRS = 4,
    parameter int unsigned CNTR_W    = 64,
    parameter int unsigned NUM_EVT   = 8,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               freeze_i,
    input  logic               bus_sel_i,
    input  logic               bus_we_i,
    input  logic               bus_re_i,
    input  logic [ADDR_W-1:0]  bus_addr_i,
    input  logic [31:0]        bus_wdata_i,
    output logic [31:0]        bus_rdata_o,
    output logic               ovf_irq_o
);

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned EVT_PAD_W = 256;
    localparam logic [7:0]  NUM_EVT_B = 8'(NUM_EVT);

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_OVF  = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_IE   = ADDR_W'(32'h08);

    // architectural state
    logic                 en_q;
    logic [NUM_CNTRS-1:0] ovf_q;
    logic [NUM_CNTRS-1:0] ovf_ie_q;
    logic [CNTR_W-1:0]    cnt_q   [NUM_CNTRS];
    logic [7:0]           evsel_q [NUM_CNTRS];
    logic [31:0]          shadow_q;
    logic [IDX_W-1:0]     shadow_idx_q;
    logic                 shadow_vld_q;
    logic [31:0]          rdata_q;
    logic                 irq_q;

    // next-state values
    logic                 en_d;
    logic [NUM_CNTRS-1:0] ovf_d;
    logic [NUM_CNTRS-1:0] ovf_ie_d;
    logic [CNTR_W-1:0]    cnt_d   [NUM_CNTRS];
    logic [7:0]           evsel_d [NUM_CNTRS];
    logic [31:0]          shadow_d;
    logic [IDX_W-1:0]     shadow_idx_d;
    logic                 shadow_vld_d;
    logic [31:0]          rd_val;

    logic [ADDR_W-1:0]    addr_w;
    logic                 wr;
    logic                 rd;
    logic                 hit_ctrl;
    logic                 hit_ovf;
    logic                 hit_ie;
    logic [NUM_CNTRS-1:0] hit_lo;
    logic [NUM_CNTRS-1:0] hit_hi;
    logic [NUM_CNTRS-1:0] hit_ev;
    logic                 clr;
    logic [NUM_CNTRS-1:0] inc;
    logic [NUM_CNTRS-1:0] ovf_set;
    logic [NUM_CNTRS-1:0] ovf_clr;
    logic [EVT_PAD_W-1:0] evt_pad;
    logic [63:0]          cnt_ext [NUM_CNTRS];

    assign bus_rdata_o = rdata_q;
    assign ovf_irq_o   = irq_q;

    // Address decode on the word-aligned offset
    always_comb begin
        addr_w   = bus_addr_i & ~ADDR_W'(3);
        wr       = bus_sel_i & bus_we_i;
        rd       = bus_sel_i & bus_re_i;
        hit_ctrl = (addr_w == A_CTRL);
        hit_ovf  = (addr_w == A_OVF);
        hit_ie   = (addr_w == A_IE);
        hit_lo   = '0;
        hit_hi   = '0;
        hit_ev   = '0;
        for (int i = 0; i < NUM_CNTRS; i++) begin
            hit_lo[i] = (addr_w == ADDR_W'(32'h40 + 32'(8 * i)));
            hit_hi[i] = (addr_w == ADDR_W'(32'h44 + 32'(8 * i)));
            hit_ev[i] = (addr_w == ADDR_W'(32'hC0 + 32'(4 * i)));
        end
        clr = wr & hit_ctrl & bus_wdata_i[1];
    end

    // Zero-extended 64-bit views of the counters for the register halves
    always_comb begin
        for (int i = 0; i < NUM_CNTRS; i++) begin
            cnt_ext[i] = 64'(cnt_q[i]);
        end
    end

    // Read mux (pre-write state) and HI shadow capture on CNT_LO reads
    always_comb begin
        rd_val       = '0;
        shadow_d     = shadow_q;
        shadow_idx_d = shadow_idx_q;
        shadow_vld_d = shadow_vld_q;
        if (hit_ctrl) rd_val = {31'b0, en_q};
        if (hit_ovf)  rd_val = 32'(ovf_q);
        if (hit_ie)   rd_val = 32'(ovf_ie_q);
        for (int i = 0; i < NUM_CNTRS; i++) begin
            if (hit_lo[i]) rd_val = cnt_ext[i][31:0];
            if (hit_hi[i]) rd_val = (shadow_vld_q && (shadow_idx_q == IDX_W'(i)))
                                    ? shadow_q : cnt_ext[i][63:32];
            if (hit_ev[i]) rd_val = 32'(evsel_q[i]);
            if (rd && hit_lo[i]) begin
                shadow_d     = cnt_ext[i][63:32];
                shadow_idx_d = IDX_W'(i);
                shadow_vld_d = 1'b1;
            end
        end
    end

    // Counter update: clear beats preload beats increment
    always_comb begin
        evt_pad = EVT_PAD_W'(evt_i);
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_CNTRS; i++) begin
            cnt_d[i] = cnt_q[i];
            inc[i]   = en_q & ~freeze_i & (evsel_q[i] < NUM_EVT_B) & evt_pad[evsel_q[i]];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (wr && hit_lo[i]) begin
                cnt_d[i] = CNTR_W'({cnt_ext[i][63:32], bus_wdata_i});
            end else if (wr && hit_hi[i]) begin
                cnt_d[i] = CNTR_W'({bus_wdata_i, cnt_ext[i][31:0]});
            end else if (inc[i]) begin
                cnt_d[i]   = cnt_q[i] + CNTR_W'(1);
                ovf_set[i] = &cnt_q[i];
            end
        end
    end

    // Control, interrupt-enable, event-select and sticky overflow next state
    always_comb begin
        en_d     = (wr && hit_ctrl) ? bus_wdata_i[0] : en_q;
        ovf_ie_d = (wr && hit_ie) ? bus_wdata_i[NUM_CNTRS-1:0] : ovf_ie_q;
        ovf_clr  = (wr && hit_ovf) ? bus_wdata_i[NUM_CNTRS-1:0] : '0;
        ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;
        for (int i = 0; i < NUM_CNTRS; i++) begin
            evsel_d[i] = (wr && hit_ev[i]) ? bus_wdata_i[7:0] : evsel_q[i];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q         <= 1'b0;
            ovf_q        <= '0;
            ovf_ie_q     <= '0;
            shadow_q     <= '0;
            shadow_idx_q <= '0;
            shadow_vld_q <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i]   <= '0;
                evsel_q[i] <= 8'hFF;
            end
        end else begin
            en_q         <= en_d;
            ovf_q        <= ovf_d;
            ovf_ie_q     <= ovf_ie_d;
            shadow_q     <= shadow_d;
            shadow_idx_q <= shadow_idx_d;
            shadow_vld_q <= shadow_vld_d;
            rdata_q      <= rd ? rd_val : 32'h0;
            irq_q        <= |(ovf_q & ovf_ie_q);
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i]   <= cnt_d[i];
                evsel_q[i] <= evsel_d[i];
            end
        end
    end

endmodule

// File: tb/tb_perf_cntr_bank.sv
// Self-checking bench for perf_cntr_bank: register tables plus directed corner sequences,
// read data checked through an expectation queue.
module tb_perf_cntr_bank;

    localparam int unsigned NUM_CNTRS = 4;
    localparam int unsigned CNTR_W    = 64;
    localparam int unsigned NUM_EVT   = 8;
    localparam int unsigned ADDR_W    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_EVT-1:0] evt;
    logic               freeze;
    logic               sel;
    logic               we;
    logic               re;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               irq;

    always #5 clk = ~clk;

    perf_cntr_bank #(
        .NUM_CNTRS(NUM_CNTRS),
        .CNTR_W   (CNTR_W),
        .NUM_EVT  (NUM_EVT),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .evt_i      (evt),
        .freeze_i   (freeze),
        .bus_sel_i  (sel),
        .bus_we_i   (we),
        .bus_re_i   (re),
        .bus_addr_i (addr),
        .bus_wdata_i(wdata),
        .bus_rdata_o(rdata),
        .ovf_irq_o  (irq)
    );

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
        string       name;
    } rv_t;

    typedef struct {
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
        string       name;
    } wv_t;

    sb_t sb_q[$];
    rv_t rst_tbl[10];
    wv_t wr_tbl[6];
    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock; afterwards compare bus_rdata_o against the queue or against idle zero
    task automatic tick();
        logic was_rd;
        sb_t  e;
        was_rd = sel & re & ~rst;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (was_rd) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got read data %h with no queued expectation", rdata);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, rdata, e.exp);
                end
            end else begin
                check("rdata_idle", rdata, 32'h0);
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        sb_t e;
        e.exp  = exp;
        e.name = nm;
        sb_q.push_back(e);
        sel = 1'b1; re = 1'b1; addr = a;
        tick();
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic run_rst_tbl();
        for (int i = 0; i < 10; i++) rd(rst_tbl[i].addr, rst_tbl[i].exp, rst_tbl[i].name);
    endtask

    initial begin
        rst_tbl[0] = '{8'h00, 32'h0,  "rst_ctrl"};
        rst_tbl[1] = '{8'h04, 32'h0,  "rst_ovf"};
        rst_tbl[2] = '{8'h08, 32'h0,  "rst_ovf_ie"};
        rst_tbl[3] = '{8'h40, 32'h0,  "rst_lo0"};
        rst_tbl[4] = '{8'h44, 32'h0,  "rst_hi0"};
        rst_tbl[5] = '{8'h48, 32'h0,  "rst_lo1"};
        rst_tbl[6] = '{8'h5C, 32'h0,  "rst_hi3"};
        rst_tbl[7] = '{8'hC0, 32'hFF, "rst_evsel0"};
        rst_tbl[8] = '{8'hCC, 32'hFF, "rst_evsel3"};
        rst_tbl[9] = '{8'h10, 32'h0,  "rst_unmapped"};

        wr_tbl[0] = '{8'hC8, 32'h0000_01AB, 8'hC8, 32'hAB, "wr_evsel2_8bit"};
        wr_tbl[1] = '{8'h08, 32'hFFFF_FFFF, 8'h08, 32'hF,  "wr_ie_width"};
        wr_tbl[2] = '{8'h08, 32'h0,         8'h08, 32'h0,  "wr_ie_zero"};
        wr_tbl[3] = '{8'h30, 32'h0000_1234, 8'h30, 32'h0,  "wr_unmapped"};
        wr_tbl[4] = '{8'hC8, 32'h0000_00FF, 8'hC8, 32'hFF, "wr_evsel2_off"};
        wr_tbl[5] = '{8'h02, 32'hFFFF_FFFC, 8'h00, 32'h0,  "wr_ctrl_lsb_ignored"};

        rst = 1'b1; evt = '0; freeze = 1'b0;
        sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        repeat (2) tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        check("irq_reset", 32'(irq), 32'h0);

        run_rst_tbl();
        for (int i = 0; i < 6; i++) begin
            wr(wr_tbl[i].waddr, wr_tbl[i].wdata);
            rd(wr_tbl[i].raddr, wr_tbl[i].exp, wr_tbl[i].name);
        end

        // 100 cycle events on counter 0
        wr(8'hC0, 32'h0);
        wr(8'h00, 32'h1);
        evt = 8'h01;
        repeat (100) tick();
        evt = '0;
        rd(8'h40, 32'd100, "t1_lo0");
        rd(8'h44, 32'h0,   "t1_hi0");
        wr(8'h00, 32'h3);

        // 64-bit wrap sets sticky overflow and a delayed interrupt
        wr(8'h48, 32'hFFFF_FFFF);
        wr(8'h4C, 32'hFFFF_FFFF);
        wr(8'hC4, 32'h2);
        wr(8'h08, 32'h2);
        rd(8'h48, 32'hFFFF_FFFF, "t2_lo1_pre");
        rd(8'h4C, 32'hFFFF_FFFF, "t2_hi1_pre");
        evt = 8'h04;
        tick();
        evt = '0;
        check("t2_irq_lag", 32'(irq), 32'h0);
        tick();
        check("t2_irq", 32'(irq), 32'h1);
        rd(8'h04, 32'h2, "t2_ovf");
        rd(8'h48, 32'h0, "t2_lo1_wrap");
        rd(8'h4C, 32'h0, "t2_hi1_wrap");
        wr(8'h04, 32'h2);
        rd(8'h04, 32'h0, "t2_ovf_clr");
        check("t2_irq_clr", 32'(irq), 32'h0);

        // freeze for 10 of 30 cycles, then select disabled
        wr(8'h00, 32'h3);
        evt = 8'h01;
        for (int k = 0; k < 30; k++) begin
            freeze = (k >= 10 && k < 20);
            tick();
        end
        freeze = 1'b0;
        evt = '0;
        rd(8'h40, 32'd20, "t3_freeze");
        wr(8'hC0, 32'hFF);
        evt = 8'h01;
        repeat (10) tick();
        evt = '0;
        rd(8'h40, 32'd20, "t3_evsel_off");

        // shadowed HI versus live HI across a 32-bit carry
        evt = 8'h02;
        wr(8'hCC, 32'h1);
        wr(8'h58, 32'hFFFF_FFFF);
        rd(8'h58, 32'hFFFF_FFFF, "t4_lo3");
        tick();
        tick();
        rd(8'h5C, 32'h0,  "t4_hi3_shadow");
        rd(8'h40, 32'd20, "t4_lo0");
        rd(8'h5C, 32'h1,  "t4_hi3_live");
        evt = '0;

        // same-cycle priorities
        evt = 8'h04;
        repeat (5) tick();
        wr(8'h00, 32'h3);
        evt = '0;
        rd(8'h48, 32'h0, "t5_clr_beats_evt");
        rd(8'h58, 32'h0, "t5_clr_all");
        evt = 8'h04;
        wr(8'h48, 32'h5);
        evt = '0;
        rd(8'h48, 32'h5, "t5_wr_beats_evt");
        wr(8'h48, 32'hFFFF_FFFF);
        wr(8'h4C, 32'hFFFF_FFFF);
        evt = 8'h04;
        wr(8'h04, 32'h2);
        evt = '0;
        rd(8'h04, 32'h2, "t5_ovf_set_wins");
        check("t5_irq", 32'(irq), 32'h1);
        rd(8'h48, 32'h0, "t5_wrap");
        wr(8'h00, 32'h3);
        rd(8'h04, 32'h2, "t5_clr_keeps_ovf");

        // reset during a read
        rd(8'h04, 32'h2, "t6_pre");
        sel = 1'b1; re = 1'b1; addr = 8'h04; rst = 1'b1;
        tick();
        rst = 1'b0; sel = 1'b0; re = 1'b0;
        check("t6_irq", 32'(irq), 32'h0);
        run_rst_tbl();

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
